// File: rtl/fixed_pkg.sv
// Shared constants for the signed fixed-point divider.
// FIXED_DIV_ROUND_EN adds one extra quotient bit for round-half-away-from-zero.
package fixed_pkg;

    localparam int D_DEF = 8;
    localparam int Q_DEF = 24;
    localparam int W_DEF = D_DEF + Q_DEF;

    localparam logic [W_DEF-1:0] MAX = {1'b0, {(W_DEF-1){1'b1}}};
    localparam logic [W_DEF-1:0] MIN = {1'b1, {(W_DEF-1){1'b0}}};

`ifdef FIXED_DIV_ROUND_EN
    localparam int ROUND_BITS = 1;
`else
    localparam int ROUND_BITS = 0;
`endif

    // Accepting edge to output_valid edge: N iterations, one DIV exit cycle, FIN.
    localparam int FIXED_DIV_LATENCY = W_DEF + Q_DEF + ROUND_BITS + 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_FIN  = 2'd2
    } div_state_t;

endpackage

// File: rtl/fixed_div_step.sv
// One radix-2 restoring division step: shift in a dividend bit, try to subtract.
module fixed_div_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] rem_i,
    input  logic         bit_i,
    input  logic [W-1:0] dvs_i,
    output logic [W-1:0] rem_o,
    output logic         q_o
);

    logic [W:0]   shifted;
    logic [W-1:0] trial;

    // Remainder stays below the divisor, so the shifted value fits in W+1 bits
    // and both candidate remainders fit back into W bits.
    always_comb begin
        shifted = {rem_i, bit_i};
        trial   = W'(shifted - {1'b0, dvs_i});
        q_o     = (shifted >= {1'b0, dvs_i});
        rem_o   = q_o ? trial : shifted[W-1:0];
    end

endmodule

// File: rtl/fixed_div.sv
// Sequential signed fixed-point divider (QD.Q), one quotient bit per cycle,
// saturating result. Define FIXED_DIV_ROUND_EN for rounded instead of truncated results.
module fixed_div
    import fixed_pkg::*;
#(
    parameter int D = D_DEF,
    parameter int Q = Q_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           new_data,
    input  logic [D+Q-1:0] a,
    input  logic [D+Q-1:0] b,
    output logic           busy,
    output logic           output_valid,
    output logic [D+Q-1:0] r,
    output logic           div_by_zero
);

    localparam int W  = D + Q;
    localparam int N  = W + Q + ROUND_BITS;
    localparam int CW = $clog2(N + 1);

    localparam logic [W-1:0] R_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] R_MIN = {1'b1, {(W-1){1'b0}}};
    // 2^(W-1) widened to the magnitude width
    localparam logic [N:0]   LIM   = {{(N+1-W){1'b0}}, 1'b1, {(W-1){1'b0}}};

    div_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0] dvd_q, dvd_d;
    logic [N-1:0] quo_q, quo_d;
    logic [W-1:0] rem_q, rem_d;
    logic [W-1:0] dvs_q, dvs_d;
    logic         neg_q, neg_d;
    logic         dbz_q, dbz_d;
    logic [W-1:0] r_q, r_d;
    logic         ov_q, ov_d;
    logic         dz_q, dz_d;

    logic [W-1:0] step_rem;
    logic         step_q;
    logic [W-1:0] a_mag, b_mag;
    logic [N:0]   mag;
    logic [W-1:0] sat_r;

    fixed_div_step #(.W(W)) u_step (
        .rem_i (rem_q),
        .bit_i (dvd_q[N-1]),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

    // Operand magnitudes; -MIN wraps to 2^(W-1), which is correct as unsigned.
    always_comb begin
        a_mag = a[W-1] ? -a : a;
        b_mag = b[W-1] ? -b : b;
    end

    // Final quotient magnitude, optionally rounded half away from zero
    always_comb begin
`ifdef FIXED_DIV_ROUND_EN
        mag = ({1'b0, quo_q} + (N+1)'(1)) >> 1;
`else
        mag = {1'b0, quo_q};
`endif
    end

    // Sign application with saturation; zero divisor forces the signed limit
    always_comb begin
        if (dbz_q)
            sat_r = neg_q ? R_MIN : R_MAX;
        else if (!neg_q && mag >= LIM)
            sat_r = R_MAX;
        else if (neg_q && mag > LIM)
            sat_r = R_MIN;
        else
            sat_r = neg_q ? -mag[W-1:0] : mag[W-1:0];
    end

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        neg_d   = neg_q;
        dbz_d   = dbz_q;
        r_d     = r_q;
        dz_d    = dz_q;
        ov_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (new_data) begin
                    state_d = ST_DIV;
                    cnt_d   = CW'(N);
                    dvd_d   = {a_mag, {(N-W){1'b0}}};
                    quo_d   = '0;
                    rem_d   = '0;
                    dvs_d   = b_mag;
                    neg_d   = a[W-1] ^ b[W-1];
                    dbz_d   = (b == '0);
                end
            end
            ST_DIV: begin
                if (cnt_q == '0) begin
                    state_d = ST_FIN;
                end else begin
                    rem_d = step_rem;
                    quo_d = {quo_q[N-2:0], step_q};
                    dvd_d = {dvd_q[N-2:0], 1'b0};
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
                r_d     = sat_r;
                dz_d    = dbz_q;
                ov_d    = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight division
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            neg_q   <= 1'b0;
            dbz_q   <= 1'b0;
            r_q     <= '0;
            ov_q    <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            neg_q   <= neg_d;
            dbz_q   <= dbz_d;
            r_q     <= r_d;
            ov_q    <= ov_d;
            dz_q    <= dz_d;
        end
    end

    assign busy         = (state_q != ST_IDLE);
    assign output_valid = ov_q;
    assign r            = r_q;
    assign div_by_zero  = dz_q;

endmodule

// File: tb/tb_fixed_div.sv
// Directed bench for fixed_div at default D=8, Q=24.
module tb_fixed_div;

`ifdef FIXED_DIV_ROUND_EN
    localparam int EXP_LAT = 59;
    localparam logic [31:0] R_2_3   = 32'h00AAAAAB;
    localparam logic [31:0] R_HALF  = 32'h00000001;
    localparam logic [31:0] R_NHALF = 32'hFFFFFFFF;
`else
    localparam int EXP_LAT = 58;
    localparam logic [31:0] R_2_3   = 32'h00AAAAAA;
    localparam logic [31:0] R_HALF  = 32'h00000000;
    localparam logic [31:0] R_NHALF = 32'h00000000;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        new_data;
    logic [31:0] a, b;
    logic        busy, output_valid, div_by_zero;
    logic [31:0] r;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        dz;
    } vec_t;

    vec_t tv[14];

    fixed_div dut (
        .clk          (clk),
        .rst          (rst),
        .new_data     (new_data),
        .a            (a),
        .b            (b),
        .busy         (busy),
        .output_valid (output_valid),
        .r            (r),
        .div_by_zero  (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called #1 after a rising edge while idle; returns #1 after the accepting edge.
    task automatic start(input logic [31:0] av, input logic [31:0] bv);
        a = av;
        b = bv;
        new_data = 1'b1;
        @(posedge clk);
        #1 new_data = 1'b0;
    endtask

    // Counts edges to output_valid, tracking that busy stayed high until then.
    task automatic wait_valid(input string nm, output int lat);
        logic busy_ok;
        busy_ok = 1'b1;
        lat = -1;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk);
            #1;
            if (output_valid) begin
                lat = k;
                break;
            end
            if (!busy) busy_ok = 1'b0;
        end
        chk({nm, " latency"}, 32'(lat), 32'(EXP_LAT));
        chk({nm, " busy before valid"}, {31'd0, busy_ok}, 32'd1);
        chk({nm, " busy in valid cycle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int lat;
        int pulses;
        logic [31:0] seen_r;

        tv[0]  = '{"one_div_two",   32'h01000000, 32'h02000000, 32'h00800000, 1'b0};
        tv[1]  = '{"m3_div_1p5",    32'hFD000000, 32'h01800000, 32'hFE000000, 1'b0};
        tv[2]  = '{"ovf_pos",       32'h64000000, 32'h00400000, 32'h7FFFFFFF, 1'b0};
        tv[3]  = '{"min_div_m1",    32'h80000000, 32'hFF000000, 32'h7FFFFFFF, 1'b0};
        tv[4]  = '{"dbz_pos",       32'h01000000, 32'h00000000, 32'h7FFFFFFF, 1'b1};
        tv[5]  = '{"dbz_neg",       32'hFF000000, 32'h00000000, 32'h80000000, 1'b1};
        tv[6]  = '{"dbz_zero",      32'h00000000, 32'h00000000, 32'h7FFFFFFF, 1'b1};
        tv[7]  = '{"two_div_three", 32'h02000000, 32'h03000000, R_2_3,        1'b0};
        tv[8]  = '{"min_div_one",   32'h80000000, 32'h01000000, 32'h80000000, 1'b0};
        tv[9]  = '{"ovf_neg",       32'h80000000, 32'h00800000, 32'h80000000, 1'b0};
        tv[10] = '{"neg_div_neg",   32'hFF000000, 32'hFE000000, 32'h00800000, 1'b0};
        tv[11] = '{"zero_div_one",  32'h00000000, 32'h01000000, 32'h00000000, 1'b0};
        tv[12] = '{"half_lsb",      32'h00000001, 32'h02000000, R_HALF,       1'b0};
        tv[13] = '{"neg_half_lsb",  32'hFFFFFFFF, 32'h02000000, R_NHALF,      1'b0};

        rst = 1'b1;
        new_data = 1'b0;
        a = '0;
        b = '0;
        #12;
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset valid", {31'd0, output_valid}, 32'd0);
        chk("reset r", r, 32'd0);
        chk("reset dbz", {31'd0, div_by_zero}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Table of single divisions
        for (int i = 0; i < 14; i++) begin
            start(tv[i].a, tv[i].b);
            chk({tv[i].name, " busy after accept"}, {31'd0, busy}, 32'd1);
            wait_valid(tv[i].name, lat);
            chk({tv[i].name, " r"}, r, tv[i].r);
            chk({tv[i].name, " dbz"}, {31'd0, div_by_zero}, {31'd0, tv[i].dz});
            @(posedge clk);
            #1;
            chk({tv[i].name, " valid one cycle"}, {31'd0, output_valid}, 32'd0);
            chk({tv[i].name, " r held"}, r, tv[i].r);
        end

        // new_data while busy is ignored
        start(32'h01000000, 32'h02000000);
        repeat (10) @(posedge clk);
        #1;
        a = 32'h64000000;
        b = 32'h00400000;
        new_data = 1'b1;
        @(posedge clk);
        #1 new_data = 1'b0;
        pulses = 0;
        seen_r = '0;
        for (int k = 0; k < 130; k++) begin
            @(posedge clk);
            #1;
            if (output_valid) begin
                pulses++;
                seen_r = r;
            end
        end
        chk("busy ignore pulses", 32'(pulses), 32'd1);
        chk("busy ignore r", seen_r, 32'h00800000);

        // Reset in mid-flight clears outputs and suppresses the result
        start(32'hFD000000, 32'h01800000);
        repeat (20) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst r", r, 32'd0);
        chk("midrst busy", {31'd0, busy}, 32'd0);
        chk("midrst valid", {31'd0, output_valid}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        pulses = 0;
        for (int k = 0; k < 80; k++) begin
            @(posedge clk);
            #1;
            if (output_valid) pulses++;
        end
        chk("midrst no valid", 32'(pulses), 32'd0);

        // Back-to-back acceptance in the output_valid cycle
        start(32'h01000000, 32'h00000000);
        wait_valid("b2b first", lat);
        chk("b2b first dbz", {31'd0, div_by_zero}, 32'd1);
        start(32'hFD000000, 32'h01800000);
        wait_valid("b2b second", lat);
        chk("b2b second r", r, 32'hFE000000);
        chk("b2b second dbz", {31'd0, div_by_zero}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fixed_div.md
FIXED_DIV -- requirements
Module: fixed_div

Interface
REQ-001 Parameter D, default 8, integer bits of the signed fixed-point format (including sign).
REQ-002 Parameter Q, default 24, fractional bits; word width W = D+Q.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 new_data  input  1  operand strobe; a and b are valid in the same cycle.
REQ-006 a  input  W  signed dividend, QD.Q.
REQ-007 b  input  W  signed divisor, QD.Q.
REQ-008 busy  output  1  high while a division is in progress.
REQ-009 output_valid  output  1  one-cycle pulse; r and div_by_zero are valid in that cycle.
REQ-010 r  output  W  signed quotient a/b, QD.Q, saturated.
REQ-011 div_by_zero  output  1  set with output_valid when b == 0.

Function
REQ-012 FSM states and transitions:
- IDLE → DIV on new_data.
- DIV → FIN when the iteration counter reaches zero.
- FIN → IDLE unconditionally.
REQ-013 Accept in IDLE:
- Capture |a|, |b| as W-bit unsigned values (|MIN| = 2^(W-1) must be representable).
- Capture the result sign as sign(a) XOR sign(b).
- Capture the zero-divisor flag.
- Load the counter with N = W+Q.
REQ-014 DIV performs one radix-2 restoring step per cycle on the dividend |a|·2^Q (W+Q bits), producing one quotient bit MSB-first, and decrements the counter.
REQ-015 FIN registers r and output_valid.
- Magnitude above 2^(W-1)-1 with positive sign: r = MAX.
- Magnitude above 2^(W-1) with negative sign: r = MIN.
- Otherwise: r = the sign-applied magnitude.
REQ-016 Rounding is truncation toward zero unless REQ-024 applies.
REQ-017 Latency: output_valid is high exactly N+2 cycles after the accepting edge (58 at defaults).
- Throughput: one result per N+2 cycles.
REQ-018 busy is high from the accepting edge until the edge that raises output_valid, and low in the output_valid cycle.
REQ-019 new_data while busy is ignored; no queuing, no error flag.
REQ-020 new_data in the output_valid cycle is accepted (back-to-back operation).
REQ-021 b == 0:
- Iterations still run, so latency is unchanged.
- r = MAX if a ≥ 0, MIN if a < 0; div_by_zero = 1.
- a == 0 with b == 0 gives MAX.
REQ-022 r and div_by_zero hold their values until the next output_valid; output_valid is low in every other cycle.

Reset
REQ-023 On rst, asynchronously and regardless of state:
- State = IDLE, counter = 0.
- busy = 0, output_valid = 0, r = 0, div_by_zero = 0.
- An in-flight division is discarded and produces no output_valid.
- First acceptance is possible on the first clock edge after rst deasserts.

Configuration
REQ-024 Macro FIXED_DIV_ROUND_EN:
- Defined: one extra quotient bit is computed (N = W+Q+1, latency N+2 = 59 at defaults). The magnitude is rounded half away from zero before sign application and saturation.
- Undefined: truncation, N = W+Q.

Structure
REQ-025 Shared package fixed_pkg holds:
- D and Q defaults, W.
- MAX = 2^(W-1)-1 and MIN = -2^(W-1).
- Constant FIXED_DIV_LATENCY, which reflects FIXED_DIV_ROUND_EN.
REQ-026 One combinational sub-module, fixed_div_step.
- Inputs: partial remainder, next dividend bit, divisor.
- Outputs: new remainder, quotient bit.
- Instantiated once and reused every cycle.

Verification
REQ-027 a=0x01000000 (1.0), b=0x02000000 (2.0), new_data for one cycle → after 58 cycles: output_valid=1, r=0x00800000, div_by_zero=0; busy high for 57 cycles before that.
REQ-028 a=0xFD000000 (-3.0), b=0x01800000 (1.5) → r=0xFE000000 (-2.0).
REQ-029 Overflow cases:
- a=0x64000000 (100.0), b=0x00400000 (0.25) → r=0x7FFFFFFF.
- a=0x80000000, b=0xFF000000 (-1.0) → r=0x7FFFFFFF.
REQ-030 Divide by zero:
- a=0x01000000, b=0 → r=0x7FFFFFFF, div_by_zero=1.
- a=0xFF000000, b=0 → r=0x80000000, div_by_zero=1.
REQ-031 Busy and reset handling:
- new_data pulsed 10 cycles into a busy division → ignored; exactly one output_valid follows.
- rst asserted 20 cycles into a division → outputs clear immediately; no output_valid follows.
- Back-to-back acceptance in the output_valid cycle → second result arrives 58 cycles later.
REQ-032 a=0x02000000 (2.0), b=0x03000000 (3.0):
- FIXED_DIV_ROUND_EN undefined → r=0x00AAAAAA.
- FIXED_DIV_ROUND_EN defined → r=0x00AAAAAB at latency 59.
